mpram_counter: RTL

- Parametrised successor of the 4x4 multiport register RAM used in the microinstruction datapath.
- Generalised in width, depth and port count, fully synchronous.
- Register 0 doubles as an up/down counter with a carry/borrow pulse.
- Provides an equality flag between register 0 and the top register, used for loop termination in microcode.

---
 rtl/mpram_counter_if.sv | 31 +++
 rtl/mpram_counter.sv | 103 ++++++++++
 2 files changed

// File: rtl/mpram_counter_if.sv
// Port bundle for mpram_counter: per-port enable/read/write controls, packed
// address/data lanes, and the register-0 counter/compare signals.
interface mpram_counter_if #(
    parameter int WIDTH  = 4,
    parameter int DEPTH  = 4,
    parameter int NPORTS = 4
);
    localparam int AW = $clog2(DEPTH);

    logic [NPORTS-1:0]       en;
    logic [NPORTS-1:0]       we;
    logic [NPORTS-1:0]       re;
    logic [NPORTS*AW-1:0]    addr;
    logic [NPORTS*WIDTH-1:0] wdata;
    logic [NPORTS*WIDTH-1:0] rdata;
    logic [NPORTS-1:0]       roe;
    logic                    cnt_inc;
    logic                    cnt_dec;
    logic                    cnt_co;
    logic                    eq;

    modport master (
        output en, we, re, addr, wdata, cnt_inc, cnt_dec,
        input  rdata, roe, cnt_co, eq
    );

    modport slave (
        input  en, we, re, addr, wdata, cnt_inc, cnt_dec,
        output rdata, roe, cnt_co, eq
    );
endinterface

// File: rtl/mpram_counter.sv
// Multiport register file with wired-OR write merge; register 0 is an up/down
// counter with carry/borrow pulse. Define MPRAM_BYPASS_EN for write-to-read forwarding.
module mpram_counter #(
    parameter int WIDTH  = 4,
    parameter int DEPTH  = 4,
    parameter int NPORTS = 4
) (
    input logic          clk,
    input logic          reset,
    mpram_counter_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0]        mem   [DEPTH];
    logic [WIDTH-1:0]        merge [DEPTH];
    logic [WIDTH-1:0]        view  [DEPTH];
    logic [DEPTH-1:0]        hit;
    logic [NPORTS-1:0]       wr_eff;
    logic [NPORTS-1:0]       roe_c;
    logic [NPORTS*WIDTH-1:0] rdata_c;
    logic [WIDTH:0]          step;
    logic                    co_q;

    // Returns {wrap, next}: wrap flags all-ones->0 on increment, 0->all-ones on decrement.
    function automatic logic [WIDTH:0] count_step(input logic [WIDTH-1:0] v, input logic up);
        logic [WIDTH-1:0] nxt;
        logic             wrap;
        if (up) begin
            nxt  = v + WIDTH'(1);
            wrap = &v;
        end else begin
            nxt  = v - WIDTH'(1);
            wrap = ~|v;
        end
        return {wrap, nxt};
    endfunction

    assign wr_eff = bus.en & bus.we & ~bus.re;
    assign roe_c  = bus.en & bus.re;
    assign step   = count_step(mem[0], bus.cnt_inc);

    // Out-of-range addresses match no register, so their writes simply vanish.
    always_comb begin
        for (int d = 0; d < DEPTH; d++) begin
            hit[d]   = 1'b0;
            merge[d] = '0;
        end
        for (int p = 0; p < NPORTS; p++) begin
            for (int d = 0; d < DEPTH; d++) begin
                if (wr_eff[p] && bus.addr[p*AW +: AW] == AW'(d)) begin
                    hit[d]   = 1'b1;
                    merge[d] = merge[d] | bus.wdata[p*WIDTH +: WIDTH];
                end
            end
        end
    end

    always_comb begin
        for (int d = 0; d < DEPTH; d++) begin
            view[d] = mem[d];
`ifdef MPRAM_BYPASS_EN
            if (hit[d]) view[d] = merge[d];
`endif
        end
    end

    always_comb begin
        rdata_c = '0;
        for (int p = 0; p < NPORTS; p++) begin
            if (roe_c[p]) begin
                for (int d = 0; d < DEPTH; d++) begin
                    if (bus.addr[p*AW +: AW] == AW'(d)) rdata_c[p*WIDTH +: WIDTH] = view[d];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int d = 0; d < DEPTH; d++) mem[d] <= '0;
            co_q <= 1'b0;
        end else begin
            for (int d = 1; d < DEPTH; d++) begin
                if (hit[d]) mem[d] <= merge[d];
            end
            // A load beats counting; inc and dec together cancel to a hold.
            if (hit[0]) begin
                mem[0] <= merge[0];
                co_q   <= 1'b0;
            end else if (bus.cnt_inc != bus.cnt_dec) begin
                mem[0] <= step[WIDTH-1:0];
                co_q   <= step[WIDTH];
            end else begin
                co_q   <= 1'b0;
            end
        end
    end

    assign bus.rdata  = rdata_c;
    assign bus.roe    = roe_c;
    assign bus.cnt_co = co_q;
    assign bus.eq     = (mem[0] == mem[DEPTH-1]);
endmodule
